// File: rtl/uart_rx_os.sv
// 16x oversampling 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote,
// false-start rejection, framing-error/break handling. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx_os #(
    parameter int unsigned CLK_FREQ = 12_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rxd_data,
    output logic       rxd_data_ready,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rx_s_q, rx_s_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    os_cnt_q, os_cnt_d;
    logic          samp7_q, samp7_d;
    logic          samp8_q, samp8_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d;
    logic          par_bit_q, par_bit_d;
`endif

    logic tick;
    logic decide;
    logic bit_end;
    logic majority;

    // Third vote is the live synchronised sample at the os 9 tick.
    always_comb begin
        tick     = (tick_cnt_q == TICK_LAST);
        decide   = tick && (os_cnt_q == 4'd9);
        bit_end  = tick && (os_cnt_q == 4'd15);
        majority = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);
    end

    always_comb begin
        sync1_d    = rx_in;
        rx_s_d     = sync1_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        os_cnt_d   = tick ? os_cnt_q + 1'b1 : os_cnt_q;
        samp7_d    = samp7_q;
        samp8_d    = samp8_q;
        if (tick && (os_cnt_q == 4'd7)) samp7_d = rx_s_q;
        if (tick && (os_cnt_q == 4'd8)) samp8_d = rx_s_q;
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (decide && majority) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (decide) shreg_d = {majority, shreg_q[7:1]};
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) par_bit_d = majority;
                if (bit_end) state_d = STOP;
            end
`endif
            // Decide half a bit early so the next start edge is caught back-to-back.
            STOP: begin
                if (decide) begin
                    if (majority) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shreg_q, par_bit_q}) begin
                            perr_d = 1'b1;
                        end else begin
                            ready_d = 1'b1;
                            data_d  = shreg_q;
                        end
`else
                        ready_d = 1'b1;
                        data_d  = shreg_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            samp7_q    <= 1'b0;
            samp8_q    <= 1'b0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rx_s_q     <= rx_s_d;
            samp7_q    <= samp7_d;
            samp8_q    <= samp8_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q     <= perr_d;
            par_bit_q  <= par_bit_d;
`endif
            // Entering START realigns the oversample grid to the detected start edge.
            if ((state_q == IDLE) && (state_d == START)) begin
                tick_cnt_q <= '0;
                os_cnt_q   <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_d;
                os_cnt_q   <= os_cnt_d;
            end
        end
    end

    assign rxd_data       = data_q;
    assign rxd_data_ready = ready_q;
    assign rx_frame_err   = ferr_q;
    assign rx_busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err  = perr_q;
`else
    assign rx_parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os at 16 clk/bit: scoreboard of expected strobes checked by a negedge monitor.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [7:0] rxd_data;
    logic       rxd_data_ready;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    uart_rx_os #(.CLK_FREQ(16_000_000), .BAUD(1_000_000)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_in          (rx_in),
        .rxd_data       (rxd_data),
        .rxd_data_ready (rxd_data_ready),
        .rx_frame_err   (rx_frame_err),
        .rx_parity_err  (rx_parity_err),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    localparam logic [2:0] K_READY  = 3'b001;
    localparam logic [2:0] K_FRAME  = 3'b010;
    localparam logic [2:0] K_PARITY = 3'b100;
    // Nominal: 2 sync clocks + 9.5 (10.5 with parity) bit times; tolerance covers detect/registration clocks.
`ifdef UART_RX_PARITY_EN
    localparam int NOMINAL_LAT = 2 + 10 * 16 + 8;
`else
    localparam int NOMINAL_LAT = 2 + 9 * 16 + 8;
`endif
    localparam int LAT_TOL = 4;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] good_byte = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rxd_data_ready || rx_frame_err || rx_parity_err) begin
            logic [2:0] obs_kind;
            exp_t       e;
            int         lat;
            logic       lat_ok;
            obs_kind = {rx_parity_err, rx_frame_err, rxd_data_ready};
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe observed strobes=%b expected none", obs_kind);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (obs_kind === e.kind) else begin
                    errors++;
                    $error("FAIL strobe_kind observed=%b expected=%b", obs_kind, e.kind);
                end
                checks++;
                assert (rxd_data === e.data) else begin
                    errors++;
                    $error("FAIL strobe_data observed=%02h expected=%02h", rxd_data, e.data);
                end
                if (e.kind == K_READY) begin
                    lat    = cyc - e.start_cyc;
                    lat_ok = (lat >= NOMINAL_LAT - LAT_TOL) && (lat <= NOMINAL_LAT + LAT_TOL);
                    checks++;
                    assert (lat_ok === 1'b1) else begin
                        errors++;
                        $error("FAIL ready_latency observed=%0d expected=%0d+/-%0d", lat, NOMINAL_LAT, LAT_TOL);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // rst_bit >= 0 asserts reset at that data bit and releases it after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                              input int rst_bit);
        exp_t e;
        if (rst_bit < 0) begin
            e.start_cyc = cyc;
            if (!stop_bit) begin
                e.kind = K_FRAME;
                e.data = good_byte;
`ifdef UART_RX_PARITY_EN
            end else if (par_flip) begin
                e.kind = K_PARITY;
                e.data = good_byte;
`endif
            end else begin
                e.kind    = K_READY;
                e.data    = b;
                good_byte = b;
            end
            exp_q.push_back(e);
        end else begin
            good_byte = 8'h00;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) reset = 1'b1;
            drive_bit(b[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`endif
        drive_bit(stop_bit);
        if (rst_bit >= 0) reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL %s pending_strobes observed=%0d expected=0", tag, exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rxd_data", rxd_data, 8'h00);
        check("reset_ready", {7'd0, rxd_data_ready}, 8'h00);
        check("reset_frame_err", {7'd0, rx_frame_err}, 8'h00);
        check("reset_parity_err", {7'd0, rx_parity_err}, 8'h00);
        check("reset_busy", {7'd0, rx_busy}, 8'h00);
        reset = 1'b0;

        // single byte
        idle(50);
        send_frame(8'h01, 1'b1, 1'b0, -1);
        idle(20);
        drain("t1_single", 400);
        check("t1_rxd_data", rxd_data, 8'h01);

        // false start: 4-clock low glitch
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t2_busy_during_glitch", {7'd0, rx_busy}, 8'h01);
        for (int i = 0; i < 10 && rx_busy !== 1'b0; i++) begin
            @(posedge clk);
            #1;
        end
        check("t2_busy_released", {7'd0, rx_busy}, 8'h00);
        idle(30);

        // framing error followed by a break, then a good byte
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        rx_in = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        idle(30);
        check("t3_rxd_data_held", rxd_data, 8'h01);
        check("t3_busy_after_break", {7'd0, rx_busy}, 8'h00);
        send_frame(8'h02, 1'b1, 1'b0, -1);
        idle(20);
        drain("t3_break", 400);
        check("t3_rxd_data", rxd_data, 8'h02);

        // back-to-back frames
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
        idle(30);
        drain("t4_back_to_back", 400);
        check("t4_rxd_data", rxd_data, 8'h05);

        // reset mid-frame
        send_frame(8'h3C, 1'b1, 1'b0, 4);
        check("t5_rxd_data_after_reset", rxd_data, 8'h00);
        check("t5_busy_after_reset", {7'd0, rx_busy}, 8'h00);
        idle(20);
        send_frame(8'h03, 1'b1, 1'b0, -1);
        idle(30);
        drain("t5_reset", 400);
        check("t5_rxd_data", rxd_data, 8'h03);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, -1);
        idle(20);
        check("t6_rxd_data_held", rxd_data, 8'h03);
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        idle(30);
        send_frame(8'h03, 1'b1, 1'b0, -1);
        idle(30);
        drain("t6_parity", 400);
        check("t6_rxd_data", rxd_data, 8'h03);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
